// File: rtl/polymem_arbiter_if.sv
// Shared write-port bundle between the burst writers (master side) and the
// polynomial RAM arbiter (slave side).
interface polymem_arbiter_if #(
  parameter int NREQ = 3,
  parameter int DW   = 26,
  parameter int AW   = 11
);
  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    done_in;
  logic [NREQ-1:0]    we_in;
  logic [NREQ*AW-1:0] addr_in;
  logic [NREQ*DW-1:0] data_in;
  logic [NREQ-1:0]    gnt;
  logic               mem_we;
  logic [AW-1:0]      mem_addr;
  logic [DW-1:0]      mem_data;
  logic               busy;
  logic               timeout;

  // Handshake: req is a level held until gnt[k] is seen; the owner then streams
  // writes while it holds gnt and ends the burst with a 1-cycle done_in pulse.
  modport master (
    output req, done_in, we_in, addr_in, data_in,
    input  gnt, mem_we, mem_addr, mem_data, busy, timeout
  );

  modport slave (
    input  req, done_in, we_in, addr_in, data_in,
    output gnt, mem_we, mem_addr, mem_data, busy, timeout
  );
endinterface

// File: rtl/polymem_arbiter.sv
// Round-robin owner-per-burst arbiter for the shared coefficient RAM write port,
// with a watchdog that revokes a grant held too long without done.
module polymem_arbiter #(
  parameter int NREQ    = 3,
  parameter int DW      = 26,
  parameter int AW      = 11,
  parameter int TIMEOUT = 1023
) (
  input  logic                    clk,
  input  logic                    rst_n,
  polymem_arbiter_if.slave        bus,
  output logic [1:0]              dbg_state,
  output logic [$clog2(NREQ)-1:0] dbg_ptr
);
  localparam int PW = $clog2(NREQ);
  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   ptr, own, pick, ptr_next;
  logic [WW-1:0]   wd;
  logic [NREQ-1:0] gnt_q;
  logic            busy_q, mem_we_q, timeout_c, found, done_own, expire;
  logic [AW-1:0]   mem_addr_q;
  logic [DW-1:0]   mem_data_q;
  logic [PW-1:0]   idx;

  // First requester at or above ptr, wrapping modulo NREQ.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = PW'((int'(ptr) + i) % NREQ);
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  // wd counts completed grant cycles, so expiry lands on the TIMEOUT-th cycle.
  assign done_own = bus.done_in[own];
  assign expire   = (wd == WW'(TIMEOUT - 1));
  assign ptr_next = (own == PW'(NREQ - 1)) ? '0 : own + 1'b1;

  always_comb begin
    state_d   = state_q;
    timeout_c = 1'b0;
    case (state_q)
      IDLE:    if (found) state_d = GRANT;
      GRANT: begin
        if (done_own) begin
          state_d = RELEASE;
        end else if (expire) begin
          state_d   = RELEASE;
          timeout_c = 1'b1;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Write path registers the owner's request in every GRANT cycle, including
  // the done cycle, so the final write lands during the RELEASE cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gnt_q      <= '0;
      own        <= '0;
      ptr        <= '0;
      wd         <= '0;
      busy_q     <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
    end else begin
      mem_we_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (found) begin
            own    <= pick;
            gnt_q  <= {{(NREQ-1){1'b0}}, 1'b1} << pick;
            busy_q <= 1'b1;
            wd     <= '0;
          end
        end
        GRANT: begin
          mem_we_q <= bus.we_in[own];
          if (bus.we_in[own]) begin
            mem_addr_q <= bus.addr_in[int'(own)*AW +: AW];
            mem_data_q <= bus.data_in[int'(own)*DW +: DW];
          end
          if (wd != WW'(TIMEOUT)) wd <= wd + 1'b1;
          if (state_d == RELEASE) begin
            gnt_q  <= '0;
            busy_q <= 1'b0;
            ptr    <= ptr_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.busy     = busy_q;
  assign bus.mem_we   = mem_we_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_data = mem_data_q;
  assign bus.timeout  = timeout_c;
  assign dbg_state    = state_q;
  assign dbg_ptr      = ptr;
endmodule

// File: tb/tb_polymem_arbiter.sv
// Directed bench for polymem_arbiter: one long-watchdog instance for bursts and
// arbitration, one TIMEOUT=16 instance for watchdog behaviour.
module tb_polymem_arbiter;
  localparam int NREQ = 3;
  localparam int DW   = 26;
  localparam int AW   = 11;
  localparam logic [1:0] S_IDLE = 2'd0, S_GRANT = 2'd1, S_RELEASE = 2'd2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  polymem_arbiter_if #(.NREQ(NREQ), .DW(DW), .AW(AW)) ifa ();
  polymem_arbiter_if #(.NREQ(NREQ), .DW(DW), .AW(AW)) ifb ();

  logic [1:0] st_a, st_b, ptr_a, ptr_b;

  polymem_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW), .TIMEOUT(1023)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa.slave), .dbg_state(st_a), .dbg_ptr(ptr_a)
  );
  polymem_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW), .TIMEOUT(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb.slave), .dbg_state(st_b), .dbg_ptr(ptr_b)
  );

  int n_cmp = 0;
  int n_bad = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      assert ($onehot0(ifa.gnt) && $onehot0(ifb.gnt))
      else $error("FAIL gnt_onehot a=%b b=%b", ifa.gnt, ifb.gnt);
    end
  end

  initial begin
    #1000000;
    $display("FAIL global_time_limit reached");
    $fatal(1, "time limit");
  end

  task automatic clear_inputs();
    ifa.req = '0; ifa.done_in = '0; ifa.we_in = '0; ifa.addr_in = '0; ifa.data_in = '0;
    ifb.req = '0; ifb.done_in = '0; ifb.we_in = '0; ifb.addr_in = '0; ifb.data_in = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic set_a(input int k, input logic we, input int addr, input int data);
    ifa.we_in[k] = we;
    ifa.addr_in[k*AW +: AW] = AW'(addr);
    ifa.data_in[k*DW +: DW] = DW'(data);
  endtask

  // Waits (bounded) for requester k's grant, then streams n writes with done on the last.
  task automatic serve_a(input int k, input int n, input int base, output int waited);
    logic [NREQ-1:0] want;
    want = NREQ'(1 << k);
    waited = 0;
    while (ifa.gnt !== want && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    ifa.req[k] = 1'b0;
    for (int i = 0; i < n; i++) begin
      set_a(k, 1'b1, base + i, base + i + 1);
      ifa.done_in[k] = (i == n - 1);
      @(negedge clk);
    end
    ifa.we_in[k] = 1'b0;
    ifa.done_in[k] = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({ifa.gnt, ifa.mem_we, ifa.busy, ifa.timeout} !== 6'b0) begin
      n_bad++; $display("FAIL reset_ctrl got=%b exp=000000", {ifa.gnt, ifa.mem_we, ifa.busy, ifa.timeout});
    end
    n_cmp++;
    if ({ifa.mem_addr, ifa.mem_data} !== '0) begin
      n_bad++; $display("FAIL reset_bus got addr=%0d data=%0d exp 0/0", ifa.mem_addr, ifa.mem_data);
    end
    n_cmp++;
    if ({st_a, ptr_a, st_b, ptr_b} !== 8'b0) begin
      n_bad++; $display("FAIL reset_state got=%b exp=00000000", {st_a, ptr_a, st_b, ptr_b});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_burst();
    int good;
    good = 0;
    ifa.req[0] = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({ifa.gnt, ifa.busy, ifa.mem_we} !== 5'b001_1_0) begin
      n_bad++; $display("FAIL t1_grant got gnt=%b busy=%b we=%b exp 001/1/0", ifa.gnt, ifa.busy, ifa.mem_we);
    end
    ifa.req[0] = 1'b0;
    for (int a = 0; a <= 756; a++) begin
      set_a(0, 1'b1, a, a);
      ifa.done_in[0] = (a == 756);
      @(negedge clk);
      if (ifa.mem_we === 1'b1 && ifa.mem_addr === AW'(a) && ifa.mem_data === DW'(a)) good++;
    end
    n_cmp++;
    if (good !== 757) begin
      n_bad++; $display("FAIL t1_writes got=%0d exp=757", good);
    end
    n_cmp++;
    if ({ifa.gnt, ifa.busy, st_a} !== {3'b000, 1'b0, S_RELEASE}) begin
      n_bad++; $display("FAIL t1_release got gnt=%b busy=%b st=%0d exp 000/0/2", ifa.gnt, ifa.busy, st_a);
    end
    ifa.we_in[0] = 1'b0;
    ifa.done_in[0] = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({ifa.mem_we, ifa.mem_addr, st_a} !== {1'b0, 11'd756, S_IDLE}) begin
      n_bad++; $display("FAIL t1_hold got we=%b addr=%0d st=%0d exp 0/756/0", ifa.mem_we, ifa.mem_addr, st_a);
    end
  endtask

  task automatic test_round_robin();
    int w0, w1, w2, w3;
    do_reset();
    ifa.req = 3'b111;
    serve_a(0, 2, 10, w0);
    n_cmp++;
    if ({ifa.gnt, ifa.busy, ptr_a} !== {3'b000, 1'b0, 2'd1}) begin
      n_bad++; $display("FAIL t2_rel0 got gnt=%b busy=%b ptr=%0d exp 000/0/1", ifa.gnt, ifa.busy, ptr_a);
    end
    ifa.req[0] = 1'b1;
    serve_a(1, 2, 20, w1);
    serve_a(2, 2, 30, w2);
    n_cmp++;
    if (ptr_a !== 2'd0) begin
      n_bad++; $display("FAIL t2_wrap got ptr=%0d exp=0", ptr_a);
    end
    serve_a(0, 2, 40, w3);
    n_cmp++;
    if ({w0, w1, w2, w3} !== {32'd1, 32'd2, 32'd2, 32'd2}) begin
      n_bad++; $display("FAIL t2_order got waits=%0d,%0d,%0d,%0d exp 1,2,2,2", w0, w1, w2, w3);
    end
    n_cmp++;
    if ({ifa.mem_addr, ifa.mem_data} !== {11'd41, 26'd42}) begin
      n_bad++; $display("FAIL t2_lastwrite got addr=%0d data=%0d exp 41/42", ifa.mem_addr, ifa.mem_data);
    end
  endtask

  task automatic test_non_owner();
    int hit5, w;
    hit5 = 0;
    do_reset();
    ifa.req[0] = 1'b1;
    @(negedge clk);
    ifa.req = 3'b010;
    set_a(1, 1'b1, 5, 999);
    for (int i = 0; i < 4; i++) begin
      set_a(0, 1'b1, 100 + i, 200 + i);
      ifa.done_in[0] = (i == 3);
      ifa.done_in[1] = (i == 1);
      @(negedge clk);
      if (ifa.mem_we === 1'b1 && (ifa.mem_addr === 11'd5 || ifa.mem_data === 26'd999)) hit5++;
      if (i == 1) begin
        n_cmp++;
        if ({ifa.gnt, st_a} !== {3'b001, S_GRANT}) begin
          n_bad++; $display("FAIL t3_foreign_done got gnt=%b st=%0d exp 001/1", ifa.gnt, st_a);
        end
      end
    end
    ifa.done_in = '0;
    ifa.we_in = '0;
    n_cmp++;
    if (hit5 !== 0) begin
      n_bad++; $display("FAIL t3_foreign_write got=%0d writes from req1 exp=0", hit5);
    end
    n_cmp++;
    if ({ifa.mem_addr, ifa.mem_data} !== {11'd103, 26'd203}) begin
      n_bad++; $display("FAIL t3_owner_last got addr=%0d data=%0d exp 103/203", ifa.mem_addr, ifa.mem_data);
    end
    serve_a(1, 1, 300, w);
    n_cmp++;
    if (w !== 2) begin
      n_bad++; $display("FAIL t3_next_grant got wait=%0d exp=2", w);
    end
  endtask

  task automatic test_timeout();
    int early;
    early = 0;
    do_reset();
    ifb.req = 3'b011;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (c == 1) ifb.req[0] = 1'b0;
      if (c < 16 && ifb.timeout === 1'b1) early++;
    end
    n_cmp++;
    if ({ifb.timeout, ifb.gnt, early[3:0]} !== {1'b1, 3'b001, 4'd0}) begin
      n_bad++; $display("FAIL t4_pulse got to=%b gnt=%b early=%0d exp 1/001/0", ifb.timeout, ifb.gnt, early);
    end
    @(negedge clk);
    n_cmp++;
    if ({ifb.gnt, ifb.timeout, ifb.busy, ptr_b} !== {3'b000, 1'b0, 1'b0, 2'd1}) begin
      n_bad++; $display("FAIL t4_revoke got gnt=%b to=%b busy=%b ptr=%0d exp 000/0/0/1", ifb.gnt, ifb.timeout, ifb.busy, ptr_b);
    end
    repeat (2) @(negedge clk);
    n_cmp++;
    if (ifb.gnt !== 3'b010) begin
      n_bad++; $display("FAIL t4_next got gnt=%b exp=010", ifb.gnt);
    end
    ifb.req[1] = 1'b0;
    ifb.done_in[1] = 1'b1;
    @(negedge clk);
    ifb.done_in[1] = 1'b0;
  endtask

  task automatic test_done_vs_timeout();
    int pulses;
    pulses = 0;
    do_reset();
    ifb.req[2] = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (ifb.gnt !== 3'b100) begin
      n_bad++; $display("FAIL t6_grant got gnt=%b exp=100", ifb.gnt);
    end
    ifb.req[2] = 1'b0;
    for (int c = 2; c <= 15; c++) begin
      @(negedge clk);
      if (ifb.timeout === 1'b1) pulses++;
    end
    @(posedge clk);
    #1 ifb.done_in[2] = 1'b1;
    @(negedge clk);
    if (ifb.timeout === 1'b1) pulses++;
    n_cmp++;
    if (ifb.gnt !== 3'b100) begin
      n_bad++; $display("FAIL t6_held got gnt=%b exp=100", ifb.gnt);
    end
    ifb.done_in[2] = 1'b0;
    @(negedge clk);
    if (ifb.timeout === 1'b1) pulses++;
    n_cmp++;
    if ({ifb.gnt, st_b, ptr_b, pulses[3:0]} !== {3'b000, S_RELEASE, 2'd0, 4'd0}) begin
      n_bad++; $display("FAIL t6_done_wins got gnt=%b st=%0d ptr=%0d pulses=%0d exp 000/2/0/0", ifb.gnt, st_b, ptr_b, pulses);
    end
  endtask

  task automatic test_reset_mid_burst();
    int w, waited;
    do_reset();
    ifa.req[0] = 1'b1;
    serve_a(0, 1, 50, w);
    ifa.req[1] = 1'b1;
    waited = 0;
    while (ifa.gnt !== 3'b010 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    n_cmp++;
    if (waited !== 2) begin
      n_bad++; $display("FAIL t5_grant1 got wait=%0d exp=2", waited);
    end
    ifa.req[1] = 1'b0;
    for (int a = 0; a < 300; a++) begin
      set_a(1, 1'b1, a, a + 1);
      @(negedge clk);
    end
    set_a(1, 1'b1, 300, 301);
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({ifa.gnt, ifa.mem_we, ifa.busy, ifa.timeout, st_a, ptr_a} !== 10'b0) begin
      n_bad++; $display("FAIL t5_abort got gnt=%b we=%b busy=%b to=%b st=%0d ptr=%0d exp all 0",
                        ifa.gnt, ifa.mem_we, ifa.busy, ifa.timeout, st_a, ptr_a);
    end
    n_cmp++;
    if ({ifa.mem_addr, ifa.mem_data} !== '0) begin
      n_bad++; $display("FAIL t5_bus got addr=%0d data=%0d exp 0/0", ifa.mem_addr, ifa.mem_data);
    end
    clear_inputs();
    rst_n = 1'b1;
    ifa.req = 3'b100;
    @(negedge clk);
    n_cmp++;
    if ({ifa.gnt, ifa.busy} !== {3'b100, 1'b1}) begin
      n_bad++; $display("FAIL t5_regrant got gnt=%b busy=%b exp 100/1", ifa.gnt, ifa.busy);
    end
    ifa.req = '0;
    ifa.done_in[2] = 1'b1;
    @(negedge clk);
    ifa.done_in[2] = 1'b0;
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single_burst();
    test_round_robin();
    test_non_owner();
    test_timeout();
    test_done_vs_timeout();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
